// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: reads two sources from the register set, forwards the
// in-flight writeback, stalls on scoreboard hazards and registers the bundle for execute.
module operand_fetch_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16,
    parameter int OPC_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic              in_wr_rd,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wr_rd,
    output logic [15:0]       stall_cnt
);

    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_next;
    logic              bypass1;
    logic              bypass2;
    logic              haz1;
    logic              haz2;
    logic              hazard;
    logic              out_free;
    logic              accept;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // The register set write lands at this edge, so a same-cycle writeback must be forwarded.
    assign bypass1 = wb_en && (wb_addr == in_rs1);
    assign bypass2 = wb_en && (wb_addr == in_rs2);

    assign src_a = !in_use_rs1 ? '0 : (bypass1 ? wb_data : rf_rdata1);
    assign src_b = !in_use_rs2 ? '0 : (bypass2 ? wb_data : rf_rdata2);

    assign haz1   = in_use_rs1 && pending[in_rs1] && !bypass1;
    assign haz2   = in_use_rs2 && pending[in_rs2] && !bypass2;
    assign hazard = haz1 || haz2;

    assign out_free = !out_valid || out_ready;
    assign in_ready = out_free && !hazard;
    assign accept   = in_valid && in_ready;

    // Clear before set so a new producer of the same register stays outstanding.
    always_comb begin
        pending_next = pending;
        if (wb_en) begin
            pending_next[wb_addr] = 1'b0;
        end
        if (accept && in_wr_rd) begin
            pending_next[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_a      <= '0;
            out_b      <= '0;
            out_rd     <= '0;
            out_wr_rd  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= in_opcode;
            out_a      <= src_a;
            out_b      <= src_b;
            out_rd     <= in_rd;
            out_wr_rd  <= in_wr_rd;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Only cycles lost to hazards count; back-pressure from execute does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (in_valid && out_free && hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
